// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared state encoding and control-vector constants
// Rev 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MDU_WAIT   = 2'd2,
        FLUSH      = 2'd3
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_flush;
        logic exmem_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_DEFAULT   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam ctrl_t CTRL_RESET     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam ctrl_t CTRL_MDU_STALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// ============================================================================
// load_use_detect : flags an ID operand that depends on a load still in EX
// Rev 1.0
// ============================================================================
`default_nettype none

module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       memread_i,
    input  logic [4:0] rd_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       use_rs1_i,
    input  logic       use_rs2_i,
    output logic       load_use_o
);

    assign load_use_o = memread_i && (rd_i != REG_ZERO) &&
                        ((use_rs1_i && (rs1_i == rd_i)) ||
                         (use_rs2_i && (rs2_i == rd_i)));

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : stall/flush sequencer for load-use, MDU and branches
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned MDU_TIMEOUT  = 64,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IDEX_memread,
    input  logic [4:0]       IDEX_rd,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             IFID_use_rs1,
    input  logic             IFID_use_rs2,
    input  logic             branch_taken,
    input  logic             mdu_start,
    input  logic             mdu_done,
    input  logic             perf_clr,
    output logic             pc_write,
    output logic             IFID_write,
    output logic             IFID_flush,
    output logic             IDEX_write,
    output logic             IDEX_flush,
    output logic             EXMEM_flush,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mdu_timeout
);

    localparam logic [3:0] FLUSH_INIT  = 4'(FLUSH_CYCLES - 1);
    localparam logic [9:0] TIMEOUT_VAL = 10'(MDU_TIMEOUT);

    state_t           state_q, state_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic [9:0]       wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_q;
    logic             load_use;
    ctrl_t            ctrl;

    load_use_detect u_load_use_detect (
        .memread_i  (IDEX_memread),
        .rd_i       (IDEX_rd),
        .rs1_i      (IFID_rs1),
        .rs2_i      (IFID_rs2),
        .use_rs1_i  (IFID_use_rs1),
        .use_rs2_i  (IFID_use_rs2),
        .load_use_o (load_use)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        ctrl        = CTRL_DEFAULT;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_INIT;
                    end
                end else if (mdu_start) begin
                    // A single-cycle MDU op (done with start) needs no freeze
                    if (!mdu_done) begin
                        ctrl       = CTRL_MDU_STALL;
                        state_d    = MDU_WAIT;
                        wait_cnt_d = 10'd1;
                    end
                end else if (load_use) begin
                    ctrl.pc_write   = 1'b0;
                    ctrl.ifid_write = 1'b0;
                    ctrl.idex_flush = 1'b1;
                    state_d         = LOAD_STALL;
                end
            end
            LOAD_STALL: state_d = RUN;
            MDU_WAIT: begin
                if (mdu_done) begin
                    state_d = RUN;
                end else if (wait_cnt_q == TIMEOUT_VAL) begin
                    timeout_d = 1'b1;
                    state_d   = RUN;
                end else begin
                    ctrl       = CTRL_MDU_STALL;
                    wait_cnt_d = wait_cnt_q + 10'd1;
                end
            end
            FLUSH: begin
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_flush = 1'b1;
                if (flush_cnt_q <= 4'd1) begin
                    flush_cnt_d = 4'd0;
                    state_d     = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: state_d = RUN;
        endcase
        // Reset overrides everything combinationally so the pipe is held immediately
        if (!rst_n) ctrl = CTRL_RESET;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            flush_cnt_q <= 4'd0;
            wait_cnt_q  <= 10'd0;
            timeout_q   <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            if (perf_clr) begin
                stall_q <= '0;
            end else if (!ctrl.pc_write && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign IFID_write   = ctrl.ifid_write;
    assign IFID_flush   = ctrl.ifid_flush;
    assign IDEX_write   = ctrl.idex_write;
    assign IDEX_flush   = ctrl.idex_flush;
    assign EXMEM_flush  = ctrl.exmem_flush;
    assign state_o      = state_q;
    assign stall_cycles = stall_q;
    assign mdu_timeout  = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl : directed vectors with hand-computed expectations
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 4;

    // Control vector order: {pc_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_flush}
    localparam logic [5:0] C_RST  = 6'b001011;
    localparam logic [5:0] C_DEF  = 6'b110100;
    localparam logic [5:0] C_LU   = 6'b000110;
    localparam logic [5:0] C_MDU  = 6'b000001;
    localparam logic [5:0] C_BR   = 6'b111110;

    logic             clk;
    logic             rst_n;
    logic             IDEX_memread;
    logic [4:0]       IDEX_rd;
    logic [4:0]       IFID_rs1;
    logic [4:0]       IFID_rs2;
    logic             IFID_use_rs1;
    logic             IFID_use_rs2;
    logic             branch_taken;
    logic             mdu_start;
    logic             mdu_done;
    logic             perf_clr;
    logic             pc_write;
    logic             IFID_write;
    logic             IFID_flush;
    logic             IDEX_write;
    logic             IDEX_flush;
    logic             EXMEM_flush;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cycles;
    logic             mdu_timeout;
    logic [5:0]       outs;

    int n_checks = 0;
    int n_errors = 0;

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (3),
        .MDU_TIMEOUT  (8),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IDEX_memread (IDEX_memread),
        .IDEX_rd      (IDEX_rd),
        .IFID_rs1     (IFID_rs1),
        .IFID_rs2     (IFID_rs2),
        .IFID_use_rs1 (IFID_use_rs1),
        .IFID_use_rs2 (IFID_use_rs2),
        .branch_taken (branch_taken),
        .mdu_start    (mdu_start),
        .mdu_done     (mdu_done),
        .perf_clr     (perf_clr),
        .pc_write     (pc_write),
        .IFID_write   (IFID_write),
        .IFID_flush   (IFID_flush),
        .IDEX_write   (IDEX_write),
        .IDEX_flush   (IDEX_flush),
        .EXMEM_flush  (EXMEM_flush),
        .state_o      (state_o),
        .stall_cycles (stall_cycles),
        .mdu_timeout  (mdu_timeout)
    );

    assign outs = {pc_write, IFID_write, IFID_flush, IDEX_write, IDEX_flush, EXMEM_flush};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IDEX_memread = 1'b0; IDEX_rd = 5'd0; IFID_rs1 = 5'd0; IFID_rs2 = 5'd0;
        IFID_use_rs1 = 1'b0; IFID_use_rs2 = 1'b0; branch_taken = 1'b0;
        mdu_start = 1'b0; mdu_done = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic drive_load_use();
        IDEX_memread = 1'b1; IDEX_rd = 5'd5; IFID_rs2 = 5'd5; IFID_use_rs2 = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #2;
        check("rst_outs", 32'(outs), 32'(C_RST));
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_stall", 32'(stall_cycles), 32'd0);
        check("rst_tmo", 32'(mdu_timeout), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Load-use on rs2: one bubble, LOAD_STALL ignores the still-present hazard
        tick(); drive_load_use(); #1;
        check("lu_outs", 32'(outs), 32'(C_LU));
        tick(); #1;
        check("lu_stall_outs", 32'(outs), 32'(C_DEF));
        check("lu_stall_state", 32'(state_o), 32'd1);
        check("lu_cnt", 32'(stall_cycles), 32'd1);
        tick(); idle(); #1;
        check("lu_back_state", 32'(state_o), 32'd0);

        // x0 destination and unused operand never stall
        IDEX_memread = 1'b1; IDEX_rd = 5'd0; IFID_use_rs1 = 1'b1; #1;
        check("x0_outs", 32'(outs), 32'(C_DEF));
        tick(); IDEX_rd = 5'd7; IFID_rs1 = 5'd7; IFID_rs2 = 5'd7; IFID_use_rs1 = 1'b0; #1;
        check("unused_outs", 32'(outs), 32'(C_DEF));
        tick(); idle(); #1;
        check("nostall_state", 32'(state_o), 32'd0);
        check("nostall_cnt", 32'(stall_cycles), 32'd1);

        // MDU op with done four cycles after start; branch/load-use ignored while frozen
        mdu_start = 1'b1; #1;
        check("mdu_start_outs", 32'(outs), 32'(C_MDU));
        tick(); idle(); #1;
        check("mdu_w1_state", 32'(state_o), 32'd2);
        check("mdu_w1_outs", 32'(outs), 32'(C_MDU));
        tick(); branch_taken = 1'b1; drive_load_use(); #1;
        check("mdu_w2_ign", 32'(outs), 32'(C_MDU));
        tick(); idle(); #1;
        check("mdu_w3_outs", 32'(outs), 32'(C_MDU));
        tick(); mdu_done = 1'b1; #1;
        check("mdu_done_outs", 32'(outs), 32'(C_DEF));
        tick(); idle(); #1;
        check("mdu_end_state", 32'(state_o), 32'd0);
        check("mdu_cnt", 32'(stall_cycles), 32'd5);

        // perf_clr on a stalling edge wins over the increment; then timeout after 8 waits
        mdu_start = 1'b1; perf_clr = 1'b1; #1;
        check("clr_outs", 32'(outs), 32'(C_MDU));
        tick(); idle(); #1;
        check("clr_cnt", 32'(stall_cycles), 32'd0);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("tmo_w%0d", i), 32'(outs), 32'(C_MDU));
            tick(); #1;
        end
        check("tmo_w8_outs", 32'(outs), 32'(C_DEF));
        check("tmo_w8_state", 32'(state_o), 32'd2);
        check("tmo_w8_flag", 32'(mdu_timeout), 32'd0);
        tick(); #1;
        check("tmo_state", 32'(state_o), 32'd0);
        check("tmo_flag", 32'(mdu_timeout), 32'd1);
        check("tmo_cnt", 32'(stall_cycles), 32'd7);

        // Second timeout brings the 4-bit counter to 15; one more stall must saturate
        mdu_start = 1'b1; #1;
        tick(); idle();
        repeat (8) tick();
        check("sat_full", 32'(stall_cycles), 32'd15);
        drive_load_use(); #1;
        check("sat_lu_outs", 32'(outs), 32'(C_LU));
        tick(); idle(); #1;
        check("sat_hold", 32'(stall_cycles), 32'd15);
        check("tmo_sticky", 32'(mdu_timeout), 32'd1);
        tick(); #1;

        // Branch beats concurrent load-use; three flush cycles, pc never held
        branch_taken = 1'b1; drive_load_use(); #1;
        check("br_c1_outs", 32'(outs), 32'(C_BR));
        tick(); branch_taken = 1'b0; mdu_start = 1'b1; #1;
        check("br_c2_state", 32'(state_o), 32'd3);
        check("br_c2_outs", 32'(outs), 32'(C_BR));
        tick(); #1;
        check("br_c3_outs", 32'(outs), 32'(C_BR));
        tick(); idle(); #1;
        check("br_end_state", 32'(state_o), 32'd0);
        check("br_end_outs", 32'(outs), 32'(C_DEF));

        // Asynchronous reset in the middle of MDU_WAIT
        mdu_start = 1'b1; #1;
        tick(); idle();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_outs", 32'(outs), 32'(C_RST));
        check("arst_state", 32'(state_o), 32'd0);
        check("arst_cnt", 32'(stall_cycles), 32'd0);
        check("arst_tmo", 32'(mdu_timeout), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick(); #1;
        check("post_rst_state", 32'(state_o), 32'd0);
        check("post_rst_outs", 32'(outs), 32'(C_DEF));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It complements the EX-stage forwarding logic and covers the cases forwarding cannot resolve:
- load-use hazards (one-bubble stall),
- multi-cycle multiply/divide occupancy of EX (freeze until done),
- taken-branch redirect (flush of wrong-path fetches).
It drives the write-enables and flushes of PC, IF/ID, ID/EX and EX/MEM, and keeps a stall performance counter.

Parameters:
FLUSH_CYCLES, 1, cycles of IF/ID flush after a taken branch (covers instruction-memory latency); legal range 1..15
MDU_TIMEOUT, 64, maximum cycles spent in MDU_WAIT before abort; legal range 2..1023
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous assert, active-low
IDEX_memread  in  1  instruction in EX is a load
IDEX_rd  in  5  destination register of instruction in EX
IFID_rs1  in  5  rs1 of instruction in ID
IFID_rs2  in  5  rs2 of instruction in ID
IFID_use_rs1  in  1  ID instruction reads rs1
IFID_use_rs2  in  1  ID instruction reads rs2
branch_taken  in  1  EX-stage branch/jump resolved taken
mdu_start  in  1  EX holds a multi-cycle MDU op, first cycle
mdu_done  in  1  MDU result valid this cycle
perf_clr  in  1  synchronous clear of stall_cycles
pc_write  out  1  PC update enable
IFID_write  out  1  IF/ID register enable
IFID_flush  out  1  IF/ID loads a NOP
IDEX_write  out  1  ID/EX register enable
IDEX_flush  out  1  ID/EX loads a bubble (control bits zero)
EXMEM_flush  out  1  EX/MEM loads a bubble
state_o  out  2  current FSM state, for debug
stall_cycles  out  CNT_W  count of cycles with pc_write=0
mdu_timeout  out  1  sticky: an MDU op exceeded MDU_TIMEOUT

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN; flush_cnt=0; wait_cnt=0; stall_cycles=0; mdu_timeout=0.
  - While rst_n=0 the outputs are forced: pc_write=0, IFID_write=0, IDEX_write=0, IFID_flush=1, IDEX_flush=1, EXMEM_flush=1.
  - Reset mid-stall or mid-flush abandons the sequence immediately; the first cycle after release is RUN.
- Load-use condition (combinational), load_use =
  - IDEX_memread & (IDEX_rd!=0) & ((IFID_use_rs1 & IFID_rs1==IDEX_rd) | (IFID_use_rs2 & IFID_rs2==IDEX_rd)).
- FSM states: RUN=0, LOAD_STALL=1, MDU_WAIT=2, FLUSH=3. Outputs are combinational from state and inputs.
- Default outputs (no event): pc_write=1, IFID_write=1, IDEX_write=1, all flushes=0.
- RUN, priority branch_taken > mdu_start > load_use:
  - branch_taken:
    - outputs: IFID_flush=1, IDEX_flush=1, pc_write=1.
    - FLUSH_CYCLES>1: next state FLUSH, flush_cnt=FLUSH_CYCLES-1. FLUSH_CYCLES=1: stay in RUN.
  - mdu_start & ~mdu_done:
    - outputs: pc_write=0, IFID_write=0, IDEX_write=0, EXMEM_flush=1.
    - next state MDU_WAIT, wait_cnt=1.
  - mdu_start & mdu_done (single-cycle op): no stall; stay in RUN.
  - load_use:
    - outputs: pc_write=0, IFID_write=0, IDEX_flush=1.
    - next state LOAD_STALL.
- LOAD_STALL:
  - Exactly 1 cycle, default outputs; load_use is not re-evaluated. Next state RUN.
  - Total penalty per load-use: one bubble.
- MDU_WAIT:
  - Outputs: stall outputs as above while mdu_done=0. On mdu_done=1, default outputs and next state RUN.
  - branch_taken and load_use are ignored (EX is frozen).
  - wait_cnt increments each cycle. If wait_cnt==MDU_TIMEOUT with mdu_done=0: set mdu_timeout, give default outputs that cycle, next state RUN.
  - mdu_done and the timeout in the same cycle count as done; mdu_timeout is not set.
- FLUSH:
  - Outputs: IFID_flush=1, pc_write=1, IDEX_flush=1. flush_cnt decrements; at 1, next state RUN.
  - branch_taken, mdu_start and load_use are ignored.
- stall_cycles:
  - +1 on each clock with rst_n=1 and pc_write=0; saturates at all-ones (no wrap).
  - perf_clr clears it to 0 and takes priority over a same-cycle increment.
- mdu_timeout is cleared only by reset.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum (RUN, LOAD_STALL, MDU_WAIT, FLUSH) with fixed 2-bit encodings,
  - REG_ZERO=5'd0,
  - the output-default constant.
- Sub-module load_use_detect: purely combinational comparator producing load_use; reused by the verification scoreboard.

Test Plan:
- Load-use: IDEX_memread=1, IDEX_rd=5, IFID_rs2=5, IFID_use_rs2=1 -> that cycle pc_write=0, IFID_write=0, IDEX_flush=1; next cycle state_o=1 with defaults; stall_cycles=1.
- x0 load and unused operand: IDEX_rd=0 matching IFID_rs1=0, then IDEX_rd=7 with IFID_rs1=7 but IFID_use_rs1=0 -> no stall in either case; state_o stays 0.
- MDU: mdu_start=1, mdu_done asserted 4 cycles later -> 4 stall cycles with EXMEM_flush=1; default outputs on the done cycle; RUN after it; stall_cycles=4.
- Timeout: MDU_TIMEOUT=8, mdu_done held 0 -> mdu_timeout=1 after 8 cycles in MDU_WAIT; state_o returns to 0; the flag stays set.
- Branch, FLUSH_CYCLES=3: branch_taken=1 together with load_use=1 -> branch wins; IFID_flush=1 for 3 consecutive cycles; pc_write never 0.
- Reset mid-MDU_WAIT, plus perf_clr concurrent with a stall -> outputs forced to their reset values asynchronously and state_o=0 after release; stall_cycles=0 after the perf_clr edge.
